// File: rtl/diff_manchester_pkg.sv
// ============================================================================
// Module  : diff_manchester_pkg
// Brief   : Shared types and helpers for the differential Manchester encoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package diff_manchester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } enc_state_t;

    localparam logic signed [15:0] C_AMP_DEFAULT = 16'sd8192;

    // Returns {first, second}: a 0 toggles the line at bit start, a 1 does not.
    function automatic logic [1:0] half_levels(input logic b, input logic line_level);
        logic first;
        first = b ? line_level : ~line_level;
        return {first, ~first};
    endfunction

endpackage

`default_nettype wire

// File: rtl/diff_manchester_encode.sv
// ============================================================================
// Module  : diff_manchester_encode
// Brief   : AXIS bit stream to differential Manchester half-symbol stream.
//           Define DIFF_MANCHESTER_BPSK_MAP_EN to emit signed +/-AMP samples.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module diff_manchester_encode
    import diff_manchester_pkg::*;
#(
    parameter int                 C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int                 C_M00_AXIS_TDATA_WIDTH = 32,
    parameter logic               INIT_LEVEL             = 1'b0,
    parameter logic signed [15:0] AMP                    = C_AMP_DEFAULT
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast
);

    enc_state_t state_q, state_d;
    logic       line_q, line_d;
    logic       level_q, level_d;
    logic       second_q, second_d;
    logic       last_lat_q, last_lat_d;
    logic       tvalid_q, tvalid_d;
    logic       tlast_q, tlast_d;

    logic       w_in_hs;
    logic       w_out_hs;
    logic [1:0] w_halves;
    logic       w_unused_inputs;

    assign w_unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], AMP};

    assign s00_axis_tready = (state_q == IDLE) || ((state_q == SECOND) && m00_axis_tready);
    assign w_in_hs         = s00_axis_tvalid && s00_axis_tready;
    assign w_out_hs        = tvalid_q && m00_axis_tready;
    assign w_halves        = half_levels(s00_axis_tdata[0], line_q);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        level_d    = level_q;
        second_d   = second_q;
        last_lat_d = last_lat_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;

        case (state_q)
            IDLE: begin
                if (w_in_hs) begin
                    level_d    = w_halves[1];
                    second_d   = w_halves[0];
                    last_lat_d = s00_axis_tlast;
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b0;
                    state_d    = FIRST;
                end
            end
            FIRST: begin
                if (w_out_hs) begin
                    level_d = second_q;
                    tlast_d = last_lat_q;
                    line_d  = second_q;
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (w_out_hs) begin
                    // line_q already holds this symbol's second half, so a
                    // back-to-back bit chains off it with no idle beat.
                    if (w_in_hs) begin
                        level_d    = w_halves[1];
                        second_d   = w_halves[0];
                        last_lat_d = s00_axis_tlast;
                        tlast_d    = 1'b0;
                        state_d    = FIRST;
                    end else begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q    <= IDLE;
            line_q     <= INIT_LEVEL;
            level_q    <= 1'b0;
            second_q   <= 1'b0;
            last_lat_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            level_q    <= level_d;
            second_q   <= second_d;
            last_lat_q <= last_lat_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

`ifdef DIFF_MANCHESTER_BPSK_MAP_EN
    logic signed [15:0] w_sample;
    assign w_sample       = level_q ? AMP : -AMP;
    assign m00_axis_tdata = tvalid_q ? {{(C_M00_AXIS_TDATA_WIDTH-16){1'b0}}, w_sample}
                                     : '0;
`else
    assign m00_axis_tdata = tvalid_q ? {{(C_M00_AXIS_TDATA_WIDTH-1){1'b0}}, level_q}
                                     : '0;
`endif

    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tlast  = tlast_q;
    assign m00_axis_tstrb  = '1;

endmodule

`default_nettype wire

// File: tb/tb_diff_manchester_encode.sv
// ============================================================================
// Module  : tb_diff_manchester_encode
// Brief   : Self-checking bench for diff_manchester_encode.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_diff_manchester_encode;
    import diff_manchester_pkg::*;

    localparam logic C_INIT = 1'b0;

    typedef struct packed {
        logic lv;
        logic last;
        logic sec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_no  = 0;
    bit   rand_gaps = 1'b0;
    logic model_line;

    logic [1:0] src[$];
    exp_t       expq[$];
    logic       obs_lv[$];
    logic       obs_last[$];
    int         obs_t[$];
    int         in_t[$];
    logic       sent[$];
    logic       secq[$];

    always #5 clk = ~clk;

    diff_manchester_encode #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .INIT_LEVEL            (C_INIT),
        .AMP                   (16'sd8192)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tready(s_tready),
        .s00_axis_tdata (s_tdata),
        .s00_axis_tstrb (s_tstrb),
        .s00_axis_tlast (s_tlast),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tready(m_tready),
        .m00_axis_tdata (m_tdata),
        .m00_axis_tstrb (m_tstrb),
        .m00_axis_tlast (m_tlast)
    );

    function automatic logic [31:0] exp_data(input logic lv);
`ifdef DIFF_MANCHESTER_BPSK_MAP_EN
        logic signed [15:0] a;
        a = lv ? 16'sd8192 : -16'sd8192;
        return {16'h0000, a};
`else
        return {31'b0, lv};
`endif
    endfunction

    function automatic logic obs_level(input logic [31:0] d);
`ifdef DIFF_MANCHESTER_BPSK_MAP_EN
        return ~d[15];
`else
        return d[0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        s_tvalid   = 1'b0;
        m_tready   = 1'b1;
        src.delete();
        expq.delete();
        model_line = C_INIT;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, account handshakes at negedge, end at posedge+1.
    task automatic cyc(input bit rdy);
        logic       vn;
        logic [1:0] h;
        exp_t       e;
        m_tready = rdy;
        vn = (src.size() > 0) && (s_tvalid || !rand_gaps || ($urandom_range(0, 2) != 0));
        if (vn && !s_tvalid) s_tstrb = 4'($urandom);
        if (vn) begin
            s_tdata = {$urandom} & 32'hFFFF_FFFE;
            s_tdata[0] = src[0][0];
            s_tlast = src[0][1];
        end else begin
            s_tlast = 1'b0;
        end
        s_tvalid = vn;
        @(negedge clk);
        if (s_tvalid && s_tready) begin
            h = half_levels(src[0][0], model_line);
            model_line = h[0];
            expq.push_back('{lv: h[1], last: 1'b0,      sec: 1'b0});
            expq.push_back('{lv: h[0], last: src[0][1], sec: 1'b1});
            sent.push_back(src[0][0]);
            in_t.push_back(cyc_no);
            void'(src.pop_front());
        end
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("tdata", m_tdata, exp_data(e.lv));
                chk("tlast", {31'b0, m_tlast}, {31'b0, e.last});
                chk("tstrb", {28'b0, m_tstrb}, 32'hF);
                obs_lv.push_back(obs_level(m_tdata));
                obs_last.push_back(m_tlast);
                obs_t.push_back(cyc_no);
                if (e.sec) secq.push_back(obs_level(m_tdata));
            end
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc, input bit rnd);
        int n;
        n = 0;
        while ((src.size() > 0 || expq.size() > 0) && n < maxc) begin
            cyc(rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
            n++;
        end
        chk("drain_timeout", {31'b0, (src.size() > 0 || expq.size() > 0)}, 32'd0);
    endtask

    task automatic clear_obs();
        obs_lv.delete();
        obs_last.delete();
        obs_t.delete();
        in_t.delete();
    endtask

    initial begin
        logic [7:0]  v8;
        logic [31:0] hd;
        logic        hl;
        logic        prev;
        int          n;

        // Reset state
        do_reset();
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_tlast",  {31'b0, m_tlast}, 32'd0);
        chk("rst_s_tready", {31'b0, s_tready}, 32'd1);

        // Bits 1,0,0,1 under continuous ready
        clear_obs();
        src.push_back(2'b01); src.push_back(2'b00);
        src.push_back(2'b00); src.push_back(2'b01);
        drain(40, 1'b0);
        chk("seq_len", obs_lv.size(), 32'd8);
        v8 = '0;
        for (int i = 0; i < 8 && i < obs_lv.size(); i++) v8[7-i] = obs_lv[i];
        chk("seq_1001", {24'b0, v8}, 32'h56);
        if (obs_t.size() == 8) chk("no_bubbles", obs_t[7] - obs_t[0], 32'd7);
        if (obs_t.size() > 0 && in_t.size() > 0) chk("latency", obs_t[0] - in_t[0], 32'd1);

        // Three-bit frame, tlast on the third bit, then a follow-on frame
        clear_obs();
        src.push_back(2'b00); src.push_back(2'b01); src.push_back(2'b11);
        drain(40, 1'b0);
        chk("frame_len", obs_last.size(), 32'd6);
        for (int i = 0; i < 6 && i < obs_last.size(); i++)
            chk("frame_tlast", {31'b0, obs_last[i]}, {31'b0, (i == 5)});
        src.push_back(2'b00); src.push_back(2'b11);
        drain(40, 1'b0);

        // Backpressure while first half is presented
        src.push_back(2'b00); src.push_back(2'b01);
        n = 0;
        while (!m_tvalid && n < 10) begin
            cyc(1'b1);
            n++;
        end
        chk("bp_reach_first", {31'b0, m_tvalid}, 32'd1);
        hd = m_tdata;
        hl = m_tlast;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            chk("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
            chk("bp_tdata", m_tdata, hd);
            chk("bp_tlast", {31'b0, m_tlast}, {31'b0, hl});
            chk("bp_s_tready", {31'b0, s_tready}, 32'd0);
        end
        drain(40, 1'b0);

        // Reset while the second half is presented
        src.push_back(2'b01);
        cyc(1'b1);
        cyc(1'b1);
        chk("pre_rst_second", {31'b0, m_tvalid}, 32'd1);
        do_reset();
        chk("rst2_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst2_s_tready", {31'b0, s_tready}, 32'd1);
        chk("rst2_tdata", m_tdata, 32'd0);
        clear_obs();
        src.push_back(2'b01);
        drain(20, 1'b0);
        chk("post_rst_len", obs_lv.size(), 32'd2);
        if (obs_lv.size() == 2) begin
            chk("post_rst_h1", {31'b0, obs_lv[0]}, 32'd0);
            chk("post_rst_h2", {31'b0, obs_lv[1]}, 32'd1);
        end

        // Random bits, gaps and backpressure; decode second halves by XOR
        do_reset();
        sent.delete();
        secq.delete();
        rand_gaps = 1'b1;
        for (int i = 0; i < 200; i++)
            src.push_back({($urandom_range(0, 7) == 0), 1'($urandom)});
        drain(5000, 1'b1);
        rand_gaps = 1'b0;
        chk("decode_len", secq.size(), sent.size());
        prev = C_INIT;
        for (int i = 0; i < secq.size() && i < sent.size(); i++) begin
            chk("decode_bit", {31'b0, secq[i] ^ prev}, {31'b0, sent[i]});
            prev = secq[i];
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
